// File: rtl/cnn_stream_pkg.sv
//============================================================================
// Module      : cnn_stream_pkg
// Description : Shared constants and state encoding for the pixel streamer
//               that feeds the CNN pipeline.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package cnn_stream_pkg;

  // One MNIST image: 28 x 28 pixels of 8 bits each.
  localparam int NUM_PIXELS = 784;
  localparam int PIX_BITS   = 8;
  localparam int DEC_BITS   = 4;

  // Decision reported when the comparator never answers.
  localparam logic [DEC_BITS-1:0] ERR_DECISION = 4'hF;

  // Streamer control states.
  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_READY  = 3'd1,
    S_STREAM = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage : cnn_stream_pkg

`default_nettype wire

// File: rtl/pixel_buffer.sv
//============================================================================
// Module      : pixel_buffer
// Description : Image store. Synchronous write port, asynchronous read port.
//               Contents are not reset; the host reloads them.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module pixel_buffer #(
  parameter int NUM_PIXELS = 784,
  parameter int PIX_BITS   = 8,
  parameter int ADDR_BITS  = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [PIX_BITS-1:0]  wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [PIX_BITS-1:0]  rdata
);

  logic [PIX_BITS-1:0] mem_q [NUM_PIXELS];

  // Host write into the selected pixel location.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : pixel_buffer

`default_nettype wire

// File: rtl/pixel_streamer.sv
//============================================================================
// Module      : pixel_streamer
// Description : Buffers one host-written image, streams it one pixel per
//               cycle into the first conv layer, then waits for (or times
//               out on) the comparator decision and latches it for the host.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module pixel_streamer #(
  parameter int NUM_PIXELS = cnn_stream_pkg::NUM_PIXELS,
  parameter int PIX_BITS   = cnn_stream_pkg::PIX_BITS,
  parameter int ADDR_BITS  = 10,
  parameter int DEC_BITS   = cnn_stream_pkg::DEC_BITS,
  parameter int TIMEOUT    = 4096,
  parameter int CNT_BITS   = 13
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [PIX_BITS-1:0] wr_data,
  output logic                wr_ready,
  input  logic                start,
  input  logic                clear,
  output logic [PIX_BITS-1:0] data_out,
  output logic                valid_out,
  input  logic                result_valid,
  input  logic [DEC_BITS-1:0] result_in,
  output logic [DEC_BITS-1:0] decision,
  output logic                done,
  output logic                error,
  output logic                busy
);

  import cnn_stream_pkg::*;

  localparam logic [ADDR_BITS-1:0] c_last_addr = ADDR_BITS'(NUM_PIXELS - 1);
  localparam logic [CNT_BITS-1:0]  c_last_wait = CNT_BITS'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0]  wait_cnt_q, wait_cnt_d;
  logic [PIX_BITS-1:0]  data_out_q, data_out_d;
  logic                 valid_out_q, valid_out_d;
  logic [DEC_BITS-1:0]  decision_q, decision_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic                 busy_q, busy_d;
  logic                 wr_ready_q, wr_ready_d;

  logic [ADDR_BITS-1:0] raddr;
  logic [PIX_BITS-1:0]  rdata;
  logic                 buf_we;

  // A host write lands only while loading; clear restarts the load instead.
  assign buf_we = (state_q == S_LOAD) && wr_en && !clear;

  // Read address looks one pixel ahead of rd_ptr so data_out is registered
  // on the same edge that advances the pointer; starting a burst reads 0.
  assign raddr = ((state_q == S_STREAM) && (rd_ptr_q != c_last_addr)) ?
                 rd_ptr_q + 1'b1 : '0;

  pixel_buffer #(
    .NUM_PIXELS (NUM_PIXELS),
    .PIX_BITS   (PIX_BITS),
    .ADDR_BITS  (ADDR_BITS)
  ) u_pixel_buffer (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Next-state and next-output computation for the control FSM.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    wait_cnt_d  = wait_cnt_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    decision_d  = decision_q;
    done_d      = done_q;
    error_d     = error_q;

    if (clear && (state_q != S_LOAD)) begin
      // Discard the image from any active state; clear beats start.
      state_d  = S_LOAD;
      wr_ptr_d = '0;
      done_d   = 1'b0;
      error_d  = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (clear) begin
            wr_ptr_d = '0;
          end else if (wr_en) begin
            if (wr_ptr_q == c_last_addr) begin
              // Final pixel: go to READY only, a same-cycle start is dropped.
              wr_ptr_d = '0;
              state_d  = S_READY;
            end else begin
              wr_ptr_d = wr_ptr_q + 1'b1;
            end
          end
        end

        S_READY: begin
          if (start) begin
            state_d     = S_STREAM;
            rd_ptr_d    = '0;
            data_out_d  = rdata;
            valid_out_d = 1'b1;
          end
        end

        S_STREAM: begin
          if (rd_ptr_q == c_last_addr) begin
            state_d    = S_WAIT;
            wait_cnt_d = '0;
          end else begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            data_out_d  = rdata;
            valid_out_d = 1'b1;
          end
        end

        S_WAIT: begin
          if (result_valid) begin
            decision_d = result_in;
            done_d     = 1'b1;
            error_d    = 1'b0;
            state_d    = S_DONE;
          end else if (wait_cnt_q == c_last_wait) begin
            decision_d = '1;
            done_d     = 1'b1;
            error_d    = 1'b1;
            state_d    = S_DONE;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end

        S_DONE: begin
          if (start) begin
            // Re-stream the image still held in the buffer.
            done_d      = 1'b0;
            error_d     = 1'b0;
            state_d     = S_STREAM;
            rd_ptr_d    = '0;
            data_out_d  = rdata;
            valid_out_d = 1'b1;
          end
        end

        default: begin
          state_d = S_LOAD;
        end
      endcase
    end

    busy_d     = (state_d == S_STREAM) || (state_d == S_WAIT);
    wr_ready_d = (state_d == S_LOAD);
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      wait_cnt_q  <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      decision_q  <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      wr_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      wait_cnt_q  <= wait_cnt_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      decision_q  <= decision_d;
      done_q      <= done_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
      wr_ready_q  <= wr_ready_d;
    end
  end

  assign wr_ready  = wr_ready_q;
  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign decision  = decision_q;
  assign done      = done_q;
  assign error     = error_q;
  assign busy      = busy_q;

endmodule : pixel_streamer

`default_nettype wire
